queue_flags: RTL and testbench

- Parametrised synchronous FIFO; next-generation data-path buffer for the acquisition chain (ADC sample staging ahead of the transmit/serialiser logic).
- Adds over the existing queue: all 2**AW entries usable, a full flag, an occupancy count and programmable almost-full/almost-empty levels.
- Also adds sticky overflow/underflow error flags and a synchronous flush.
- Show-ahead read: the head word is visible on out whenever the FIFO is not empty.

---
 rtl/vdas_fifo_pkg.sv | 17 +
 rtl/queue_mem.sv | 25 ++
 rtl/queue_flags.sv | 104 ++++++++++
 tb/tb_queue_flags.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vdas_fifo_pkg.sv
// Shared definitions for the acquisition-chain FIFOs: default geometry, depth and
// elaboration-time legality checks for the almost-full/almost-empty levels.
package vdas_fifo_pkg;

    localparam int unsigned NBITS_DEF = 8;
    localparam int unsigned AW_DEF    = 4;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic bit levels_ok(input int unsigned aw, input int unsigned afull_lvl,
                                     input int unsigned aempty_lvl);
        return (afull_lvl >= 1) && (afull_lvl <= depth(aw)) && (aempty_lvl < depth(aw));
    endfunction

endpackage

// File: rtl/queue_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module queue_mem #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             ck,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NBITS-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [NBITS-1:0] rdata
);

    logic [NBITS-1:0] mem [2**AW];

    always_ff @(posedge ck) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/queue_flags.sv
// Show-ahead synchronous FIFO with full/empty/almost flags, occupancy count,
// sticky overflow/underflow and synchronous flush. All outputs decode registered state.
module queue_flags
    import vdas_fifo_pkg::*;
#(
    parameter int unsigned NBITS      = NBITS_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clr,
    input  logic [NBITS-1:0] in,
    input  logic             ld,
    input  logic             pp,
    output logic [NBITS-1:0] out,
    output logic             em,
    output logic             fu,
    output logic             af,
    output logic             ae,
    output logic [AW:0]      cnt,
    output logic             ovf,
    output logic             udf
);

    if (!levels_ok(AW, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_levels
        $fatal(1, "queue_flags: AFULL_LVL/AEMPTY_LVL out of range for AW");
    end

    localparam logic [AW:0] AF_LVL = (AW + 1)'(AFULL_LVL);
    localparam logic [AW:0] AE_LVL = (AW + 1)'(AEMPTY_LVL);
    localparam logic [AW:0] ONE    = (AW + 1)'(1);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic [NBITS-1:0] rdata;

    assign em = (wptr_q == rptr_q);
    assign fu = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the slot the write lands in, so a full FIFO still accepts ld&pp.
    assign wr_acc = ld & ~clr & (~fu | pp);
    assign rd_acc = pp & ~clr & ~em;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ONE;
            if (rd_acc) rptr_d = rptr_q + ONE;
            if (wr_acc && !rd_acc) cnt_d = cnt_q + ONE;
            if (rd_acc && !wr_acc) cnt_d = cnt_q - ONE;
            if (ld && fu && !pp) ovf_d = 1'b1;
            if (pp && em)        udf_d = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    queue_mem #(
        .NBITS (NBITS),
        .AW    (AW)
    ) u_mem (
        .ck    (ck),
        .we    (wr_acc),
        .waddr (wptr_q[AW-1:0]),
        .wdata (in),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign out = em ? '0 : rdata;
    assign cnt = cnt_q;
    assign af  = (cnt_q >= AF_LVL);
    assign ae  = (cnt_q <= AE_LVL);
    assign ovf = ovf_q;
    assign udf = udf_q;

endmodule

// File: tb/tb_queue_flags.sv
// Self-checking bench for queue_flags: directed scenarios plus random traffic,
// compared against a queue-based behavioural model.
module tb_queue_flags;

    localparam int DEPTH = 16;

    logic       ck = 1'b0;
    logic       rst, clr, ld, pp;
    logic [7:0] din, dout;
    logic       em, fu, af, ae, ovf, udf;
    logic [4:0] cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_udf;

    always #5 ck = ~ck;

    queue_flags dut (
        .ck  (ck),
        .rst (rst),
        .clr (clr),
        .in  (din),
        .ld  (ld),
        .pp  (pp),
        .out (dout),
        .em  (em),
        .fu  (fu),
        .af  (af),
        .ae  (ae),
        .cnt (cnt),
        .ovf (ovf),
        .udf (udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    // Model applies the rules directly: flush, else pop-then-push with drop on full.
    task automatic model_edge(input bit l, input bit p, input bit c, input logic [7:0] d);
        int sz;
        if (c) begin
            model_reset();
            return;
        end
        sz = q.size();
        if (l && sz == DEPTH && !p) m_ovf = 1;
        if (p && sz == 0) m_udf = 1;
        if (p && sz > 0) void'(q.pop_front());
        if (l && (sz < DEPTH || p)) q.push_back(d);
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        check({tag, ".cnt"}, 32'(cnt), 32'(sz));
        check({tag, ".em"},  32'(em),  32'(sz == 0));
        check({tag, ".fu"},  32'(fu),  32'(sz == DEPTH));
        check({tag, ".af"},  32'(af),  32'(sz >= 12));
        check({tag, ".ae"},  32'(ae),  32'(sz <= 2));
        check({tag, ".out"}, 32'(dout), (sz > 0) ? 32'(q[0]) : 32'h0);
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".udf"}, 32'(udf), 32'(m_udf));
    endtask

    // Entered at a negedge; leaves at the following negedge.
    task automatic step(input string tag, input bit l, input bit p, input bit c,
                        input logic [7:0] d);
        ld  = l;
        pp  = p;
        clr = c;
        din = d;
        @(posedge ck);
        model_edge(l, p, c, d);
        #1;
        check_all(tag);
        @(negedge ck);
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        ld  = 1'b0;
        pp  = 1'b0;
        din = 8'h00;
        model_reset();
        #2;
        check_all("reset");
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);

        // Fill with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            step("fill", 1, 0, 0, 8'(8'h10 + i));
            if (i == 11) check("af_at_12", 32'(af), 32'h1);
        end
        check("full_cnt", 32'(cnt), 32'd16);
        check("full_out", 32'(dout), 32'h10);

        step("ovf", 1, 0, 0, 8'hAA);
        check("ovf_set", 32'(ovf), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("drain1_data", 32'(dout), 32'(8'h10 + i));
            step("drain1", 0, 1, 0, 8'h00);
        end

        // Full plus simultaneous ld&pp
        for (int i = 0; i < 16; i++) step("refill", 1, 0, 0, 8'(8'h10 + i));
        step("full_ldpp", 1, 1, 0, 8'h55);
        check("full_ldpp_cnt", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) step("drain2", 0, 1, 0, 8'h00);

        // Empty plus simultaneous ld&pp
        step("empty_ldpp", 1, 1, 0, 8'h3C);
        check("empty_ldpp_out", 32'(dout), 32'h3C);
        check("empty_ldpp_udf", 32'(udf), 32'h1);
        step("empty_pop", 0, 1, 0, 8'h00);

        // Interleaved traffic holding cnt in 1..3 so the pointers wrap
        step("il_pre", 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            bit l, p;
            l = (q.size() == 1) ? 1'b1 : (q.size() == 3) ? 1'b0 : 1'($urandom);
            p = (q.size() == 3) ? 1'b1 : (q.size() == 1) ? 1'b0 : ~l;
            step("interleave", l, p, 0, 8'($urandom));
        end

        // Reach cnt=5 with ovf set, then flush alongside ld
        step("pre_clr", 0, 0, 1, 8'h00);
        for (int i = 0; i < 17; i++) step("clr_fill", 1, 0, 0, 8'(i));
        for (int i = 0; i < 11; i++) step("clr_pop", 0, 1, 0, 8'h00);
        check("clr_pre_cnt", 32'(cnt), 32'd5);
        step("clr_ld", 1, 1, 1, 8'hEE);
        check("clr_em", 32'(em), 32'h1);
        check("clr_ovf", 32'(ovf), 32'h0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step("burst", 1, 0, 0, 8'(8'hC0 + i));
        ld  = 1'b1;
        din = 8'hC3;
        @(posedge ck);
        model_edge(1, 0, 0, 8'hC3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge ck);
        ld  = 1'b0;
        rst = 1'b1;
        @(negedge ck);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit l, p, c;
            l = ($urandom_range(0, 99) < 55);
            p = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 3);
            step("random", l, p, c, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
